// File: rtl/digit_scan_ctrl.sv
// Eight-digit seven-segment scan controller: prescaled digit select, active-low anodes, dead-time blanking.
// Optional SCAN_DP_EN macro adds a per-digit decimal point input (dp_mask) and active-low output (dp_n).
module digit_scan_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] blank_mask,
`ifdef SCAN_DP_EN
  input  logic [7:0] dp_mask,
  output logic       dp_n,
`endif
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST  = (DEAD_CYCLES > 0) ? DW'(DEAD_CYCLES - 1) : '0;
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [DW-1:0] dead_r;

  logic [2:0] sel_nxt_s;
  logic [7:0] cur_pat_s;
  logic [7:0] nxt_pat_s;
  logic       presc_last_s;
  logic       dead_done_s;

  function automatic logic [7:0] anode_pat(input logic [2:0] idx, input logic [7:0] mask);
    anode_pat = ~(8'd1 << idx) | mask;
  endfunction

  // Anode patterns for the current and the following digit, plus counter terminal flags
  always_comb begin
    sel_nxt_s    = sel + 3'd1;
    cur_pat_s    = anode_pat(sel, blank_mask);
    nxt_pat_s    = anode_pat(sel_nxt_s, blank_mask);
    presc_last_s = (presc_r == PRESC_LAST);
    dead_done_s  = (dead_r == DEAD_LAST);
  end

`ifdef SCAN_DP_EN
  logic cur_dp_s;
  logic nxt_dp_s;
  logic dp_r;

  // Decimal point level for the current and the following digit
  always_comb begin
    cur_dp_s = ~dp_mask[sel] & ~blank_mask[sel];
    nxt_dp_s = ~dp_mask[sel_nxt_s] & ~blank_mask[sel_nxt_s];
  end

  assign dp_n = dp_r;
`endif

  // Scan FSM: every output is registered so the mux select and anodes change on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      presc_r <= '0;
      dead_r  <= '0;
      sel     <= 3'd0;
      an      <= 8'hFF;
      tick    <= 1'b0;
`ifdef SCAN_DP_EN
      dp_r    <= 1'b1;
`endif
    end else if (!en) begin
      state_r <= IDLE;
      presc_r <= '0;
      dead_r  <= '0;
      an      <= 8'hFF;
      tick    <= 1'b0;
`ifdef SCAN_DP_EN
      dp_r    <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= ON;
          presc_r <= '0;
          dead_r  <= '0;
          an      <= cur_pat_s;
          tick    <= 1'b0;
`ifdef SCAN_DP_EN
          dp_r    <= cur_dp_s;
`endif
        end
        ON: begin
          if (presc_last_s) begin
            presc_r <= '0;
            sel     <= sel_nxt_s;
            tick    <= 1'b1;
            // Without dead-time the next digit lights on the same edge sel advances
            if (HAS_DEAD) begin
              state_r <= DEAD;
              an      <= 8'hFF;
`ifdef SCAN_DP_EN
              dp_r    <= 1'b1;
`endif
            end else begin
              state_r <= ON;
              an      <= nxt_pat_s;
`ifdef SCAN_DP_EN
              dp_r    <= nxt_dp_s;
`endif
            end
          end else begin
            presc_r <= presc_r + PW'(1);
            an      <= cur_pat_s;
            tick    <= 1'b0;
`ifdef SCAN_DP_EN
            dp_r    <= cur_dp_s;
`endif
          end
        end
        DEAD: begin
          tick <= 1'b0;
          if (dead_done_s) begin
            dead_r  <= '0;
            state_r <= ON;
            an      <= cur_pat_s;
`ifdef SCAN_DP_EN
            dp_r    <= cur_dp_s;
`endif
          end else begin
            dead_r  <= dead_r + DW'(1);
            an      <= 8'hFF;
`ifdef SCAN_DP_EN
            dp_r    <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          presc_r <= '0;
          dead_r  <= '0;
          an      <= 8'hFF;
          tick    <= 1'b0;
`ifdef SCAN_DP_EN
          dp_r    <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: TICK_DIV=4/DEAD_CYCLES=1 instance and TICK_DIV=2/DEAD_CYCLES=0 instance.
module tb_digit_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] mask;
  logic [2:0] sel;
  logic [7:0] an;
  logic       tick;
  logic       en0;
  logic [7:0] mask0;
  logic [2:0] sel0;
  logic [7:0] an0;
  logic       tick0;
`ifdef SCAN_DP_EN
  logic [7:0] dp_mask;
  logic       dp_n;
  logic [7:0] dp_mask0;
  logic       dp_n0;
`endif

  int checks;
  int failures;
  int j;
  int ph;
  logic [2:0] s;
  logic [7:0] ea;
  logic       et;

  digit_scan_ctrl #(.TICK_DIV(4), .DEAD_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .blank_mask(mask),
`ifdef SCAN_DP_EN
    .dp_mask(dp_mask), .dp_n(dp_n),
`endif
    .sel(sel), .an(an), .tick(tick)
  );

  digit_scan_ctrl #(.TICK_DIV(2), .DEAD_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en0), .blank_mask(mask0),
`ifdef SCAN_DP_EN
    .dp_mask(dp_mask0), .dp_n(dp_n0),
`endif
    .sel(sel0), .an(an0), .tick(tick0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    mask     = 8'h00;
    en0      = 1'b0;
    mask0    = 8'h00;
`ifdef SCAN_DP_EN
    dp_mask  = 8'h81;
    dp_mask0 = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_an", an, 8'hFF);
    chk("rst_tick", 8'(tick), 8'h00);
    chk("rst_sel0", 8'(sel0), 8'h00);
    chk("rst_an0", an0, 8'hFF);
`ifdef SCAN_DP_EN
    chk("rst_dp", 8'(dp_n), 8'h01);
`endif

    // Full frame plus wrap; blank digit 2 from edge 42 onward
    reset_n = 1'b1;
    en      = 1'b1;
    for (int k = 0; k < 67; k++) begin
      if (k == 42) mask = 8'h04;
      step();
      j  = k / 5;
      ph = k % 5;
      if (ph < 4) begin
        s  = 3'(j % 8);
        ea = ~(8'd1 << s) | mask;
        et = 1'b0;
      end else begin
        s  = 3'((j + 1) % 8);
        ea = 8'hFF;
        et = 1'b1;
      end
      chk($sformatf("scan_sel k=%0d", k), 8'(sel), 8'(s));
      chk($sformatf("scan_an k=%0d", k), an, ea);
      chk($sformatf("scan_tick k=%0d", k), 8'(tick), 8'(et));
`ifdef SCAN_DP_EN
      chk($sformatf("scan_dp k=%0d", k), 8'(dp_n),
          (ph < 4) ? 8'(~dp_mask[s] & ~mask[s]) : 8'h01);
`endif
    end

    // en dropped mid-ON at sel=5, restored after 10 clocks
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("off_sel i=%0d", i), 8'(sel), 8'h05);
      chk($sformatf("off_an i=%0d", i), an, 8'hFF);
      chk($sformatf("off_tick i=%0d", i), 8'(tick), 8'h00);
`ifdef SCAN_DP_EN
      chk($sformatf("off_dp i=%0d", i), 8'(dp_n), 8'h01);
`endif
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("resume_an i=%0d", i), an, 8'hDF);
      chk($sformatf("resume_sel i=%0d", i), 8'(sel), 8'h05);
      chk($sformatf("resume_tick i=%0d", i), 8'(tick), 8'h00);
    end
    step();
    chk("resume_adv_sel", 8'(sel), 8'h06);
    chk("resume_adv_an", an, 8'hFF);
    chk("resume_adv_tick", 8'(tick), 8'h01);
    step();
    chk("resume_on6_an", an, 8'hBF);

    // Advance to digit 3 ON, then pulse reset between edges
    repeat (24) @(posedge clk);
    #1;
    step();
    chk("pre_rst_sel", 8'(sel), 8'h03);
    chk("pre_rst_an", an, 8'hF7);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sel", 8'(sel), 8'h00);
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_tick", 8'(tick), 8'h00);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("restart_an i=%0d", i), an, 8'hFE);
      chk($sformatf("restart_sel i=%0d", i), 8'(sel), 8'h00);
    end
    step();
    chk("restart_adv_sel", 8'(sel), 8'h01);
    chk("restart_adv_tick", 8'(tick), 8'h01);
    chk("dark0_an", an0, 8'hFF);

    // No dead-time instance: digit changes every 2 clocks with no all-off cycle
    en0 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      s = 3'((k / 2) % 8);
      chk($sformatf("nodead_sel k=%0d", k), 8'(sel0), 8'(s));
      chk($sformatf("nodead_an k=%0d", k), an0, ~(8'd1 << s));
      chk($sformatf("nodead_tick k=%0d", k), 8'(tick0), ((k >= 2) && (k % 2 == 0)) ? 8'h01 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
